// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters with registered
// sync, display-enable, coordinate and strobe outputs.
module video_timing_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter logic        H_SYNC_POL = 1'b0,
  parameter logic        V_SYNC_POL = 1'b0
) (
  input  logic        i_hdmi_clk,
  input  logic        i_reset_n,
  input  logic        i_enable,
  output logic [2:0]  o_hve_sync,
  output logic [11:0] o_x,
  output logic [11:0] o_y,
  output logic        o_line_start,
  output logic        o_frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_zero
    $error("video_timing_gen: every timing parameter must be non-zero");
  end
  if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_big
    $error("video_timing_gen: H_TOTAL/V_TOTAL must not exceed 4096");
  end

  localparam logic [12:0] H_LAST = 13'(H_TOTAL - 1);
  localparam logic [12:0] V_LAST = 13'(V_TOTAL - 1);
  localparam logic [12:0] H_DE   = 13'(H_ACTIVE);
  localparam logic [12:0] H_SS   = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] H_SE   = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] V_DE   = 13'(V_ACTIVE);
  localparam logic [12:0] V_SS   = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] V_SE   = 13'(V_ACTIVE + V_FP + V_SYNC);

  logic [11:0] h_cnt_q, h_cnt_d;
  logic [11:0] v_cnt_q, v_cnt_d;
  logic        de_q, de_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic [11:0] x_q, x_d;
  logic [11:0] y_q, y_d;
  logic        ls_q, ls_d;
  logic        fs_q, fs_d;

  logic [12:0] h_w, v_w;
  logic        h_wrap, v_wrap;

  always_comb begin
    h_w    = {1'b0, h_cnt_q};
    v_w    = {1'b0, v_cnt_q};
    h_wrap = (h_w == H_LAST);
    v_wrap = (v_w == V_LAST);

    h_cnt_d = h_wrap ? 12'd0 : h_cnt_q + 12'd1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) v_cnt_d = v_wrap ? 12'd0 : v_cnt_q + 12'd1;

    // Outputs decode the pre-edge counters; disabled means idle at origin.
    de_d = 1'b0;
    hs_d = ~H_SYNC_POL;
    vs_d = ~V_SYNC_POL;
    x_d  = 12'd0;
    y_d  = 12'd0;
    ls_d = 1'b0;
    fs_d = 1'b0;
    if (i_enable) begin
      de_d = (h_w < H_DE) && (v_w < V_DE);
      if (h_w >= H_SS && h_w < H_SE) hs_d = H_SYNC_POL;
      if (v_w >= V_SS && v_w < V_SE) vs_d = V_SYNC_POL;
      x_d  = h_cnt_q;
      y_d  = v_cnt_q;
      ls_d = (h_cnt_q == 12'd0);
      fs_d = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
    end else begin
      h_cnt_d = 12'd0;
      v_cnt_d = 12'd0;
    end
  end

  always_ff @(posedge i_hdmi_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      h_cnt_q <= 12'd0;
      v_cnt_q <= 12'd0;
      de_q    <= 1'b0;
      hs_q    <= ~H_SYNC_POL;
      vs_q    <= ~V_SYNC_POL;
      x_q     <= 12'd0;
      y_q     <= 12'd0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

  assign o_hve_sync    = {de_q, vs_q, hs_q};
  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_line_start  = ls_q;
  assign o_frame_start = fs_q;

endmodule
